// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares the single external SRAM port between N_REQ engines (bitstream decoder, IDCT
// fetch/write-back, colour-space conversion). Round-robin grant with an optional burst lock.
// The SRAM address, write data and write enable are registered. Reads are tracked through a
// tag pipeline, so returning data is steered back to the requester that issued it.
//
// Optional feature (compile-time macro SRAM_ARB_WR_RD_BUBBLE_EN):
//   When the grant passes to a different requester and the last accepted access was a write,
//   one idle cycle (ArbBubble) is inserted. During that cycle grant_o is zero and SRAM_we_n is
//   high. Without the macro, ownership changes back-to-back.
//
// Parameters:
//   N_REQ       number of requesters (2..4)
//   RD_LATENCY  cycles from the SRAM_address edge to valid SRAM_read_data (>= 1)
//
// Ports:
//   Clock_50         system clock
//   Resetn           asynchronous active-low reset
//   req_i            per-requester access request
//   lock_i           per-requester burst lock (owner keeps the grant while high)
//   we_n_i           per-requester write enable, active-low
//   address_i        packed 18-bit addresses, requester k at [18k+17:18k]
//   wdata_i          packed 16-bit write data, requester k at [16k+15:16k]
//   grant_o          one-hot current owner, or zero
//   rvalid_o         one-cycle pulse marking rdata_o as belonging to requester k
//   rdata_o          read data, passed straight from SRAM_read_data
//   SRAM_address     registered address to the SRAM controller
//   SRAM_write_data  registered write data to the SRAM controller
//   SRAM_we_n        registered write enable to the SRAM controller, active-low
//   SRAM_read_data   read data from the SRAM controller

module sram_port_arbiter #(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  Clock_50,
    input  logic                  Resetn,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ-1:0]      lock_i,
    input  logic [N_REQ-1:0]      we_n_i,
    input  logic [18*N_REQ-1:0]   address_i,
    input  logic [16*N_REQ-1:0]   wdata_i,
    output logic [N_REQ-1:0]      grant_o,
    output logic [N_REQ-1:0]      rvalid_o,
    output logic [15:0]           rdata_o,
    output logic [17:0]           SRAM_address,
    output logic [15:0]           SRAM_write_data,
    output logic                  SRAM_we_n,
    input  logic [15:0]           SRAM_read_data
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [IdxW-1:0] idx_t;

`ifdef SRAM_ARB_WR_RD_BUBBLE_EN
    typedef enum logic [1:0] {
        ArbIdle,
        ArbOwned,
        ArbBubble
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        ArbIdle,
        ArbOwned
    } arb_state_e;
`endif

    arb_state_e state_q, state_d;
    idx_t       owner_q, owner_d;   // current owner; also holds the chosen winner during a bubble
    idx_t       ptr_q, ptr_d;       // round-robin search start, (last_owner + 1) mod N_REQ
    logic [N_REQ-1:0] grant_q, grant_d;

    logic        accept;
    logic        rearb;
    logic        win_found;
    idx_t        win_idx;
    logic        cur_we_n;
    logic [17:0] cur_addr;
    logic [15:0] cur_wdata;

`ifdef SRAM_ARB_WR_RD_BUBBLE_EN
    logic last_wr_q, last_wr_d;
`endif

    logic [RD_LATENCY:0]            tag_vld_q;
    logic [RD_LATENCY:0][IdxW-1:0]  tag_own_q;

    // ------------------------------------------------------------------------------------
    // Owner's request fields
    // ------------------------------------------------------------------------------------
    always_comb begin
        cur_we_n  = we_n_i[owner_q];
        cur_addr  = address_i[int'(owner_q)*18 +: 18];
        cur_wdata = wdata_i[int'(owner_q)*16 +: 16];
    end

    assign accept = (state_q == ArbOwned) && req_i[owner_q];
    assign rearb  = (state_q == ArbIdle) || ((state_q == ArbOwned) && !lock_i[owner_q]);

    // ------------------------------------------------------------------------------------
    // Round-robin winner search starting at ptr_q, wrapping
    // ------------------------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!win_found && req_i[(int'(ptr_q) + i) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = idx_t'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // Arbitration FSM: next state
    // ------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef SRAM_ARB_WR_RD_BUBBLE_EN
        // Includes the access being accepted in this very cycle.
        last_wr_d = last_wr_q;
        if (accept) begin
            last_wr_d = ~cur_we_n;
        end
`endif

        unique case (state_q)
`ifdef SRAM_ARB_WR_RD_BUBBLE_EN
            ArbBubble: begin
                // owner_q already holds the winner chosen when the bubble was entered.
                state_d = ArbOwned;
            end
`endif
            ArbIdle, ArbOwned: begin
                if (rearb) begin
                    if (win_found) begin
                        owner_d = win_idx;
                        state_d = ArbOwned;
                        ptr_d   = (win_idx == idx_t'(N_REQ - 1)) ? '0
                                                                 : idx_t'(win_idx + idx_t'(1));
`ifdef SRAM_ARB_WR_RD_BUBBLE_EN
                        if ((state_q == ArbOwned) && (win_idx != owner_q) && last_wr_d) begin
                            state_d = ArbBubble;
                        end
`endif
                    end else begin
                        state_d = ArbIdle;
                    end
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_comb begin
        grant_d = '0;
        if (state_d == ArbOwned) begin
            grant_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ArbIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

`ifdef SRAM_ARB_WR_RD_BUBBLE_EN
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            last_wr_q <= 1'b0;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end
`endif

    assign grant_o = grant_q;

    // ------------------------------------------------------------------------------------
    // SRAM port registers. Without an accepted access the write enable drops back to
    // inactive and address/data hold, so no spurious write is ever driven.
    // ------------------------------------------------------------------------------------
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
        end else if (accept) begin
            SRAM_address    <= cur_addr;
            SRAM_write_data <= cur_wdata;
            SRAM_we_n       <= cur_we_n;
        end else begin
            SRAM_we_n       <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------------------
    // Read tag pipeline. Stage 0 is loaded at the issue edge; the last stage lines up with
    // SRAM_read_data RD_LATENCY cycles later. Never flushed by grant changes.
    // ------------------------------------------------------------------------------------
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            tag_vld_q <= '0;
            tag_own_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[RD_LATENCY-1:0], accept & cur_we_n};
            tag_own_q <= {tag_own_q[RD_LATENCY-1:0], owner_q};
        end
    end

    always_comb begin
        rvalid_o = '0;
        if (tag_vld_q[RD_LATENCY]) begin
            rvalid_o[tag_own_q[RD_LATENCY]] = 1'b1;
        end
    end

    assign rdata_o = SRAM_read_data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a transaction-level model.

module tb_sram_port_arbiter;

    localparam int N  = 3;
    localparam int RL = 2;

    logic              Clock_50 = 1'b0;
    logic              Resetn   = 1'b0;
    logic [N-1:0]      req_i;
    logic [N-1:0]      lock_i;
    logic [N-1:0]      we_n_i;
    logic [18*N-1:0]   address_i;
    logic [16*N-1:0]   wdata_i;
    logic [N-1:0]      grant_o;
    logic [N-1:0]      rvalid_o;
    logic [15:0]       rdata_o;
    logic [17:0]       SRAM_address;
    logic [15:0]       SRAM_write_data;
    logic              SRAM_we_n;
    logic [15:0]       SRAM_read_data = 16'h0;

    int n_checks = 0;
    int n_errors = 0;

    sram_port_arbiter #(
        .N_REQ      (N),
        .RD_LATENCY (RL)
    ) dut (
        .Clock_50        (Clock_50),
        .Resetn          (Resetn),
        .req_i           (req_i),
        .lock_i          (lock_i),
        .we_n_i          (we_n_i),
        .address_i       (address_i),
        .wdata_i         (wdata_i),
        .grant_o         (grant_o),
        .rvalid_o        (rvalid_o),
        .rdata_o         (rdata_o),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data)
    );

    always #10 Clock_50 = ~Clock_50;

    // Content of the external memory as seen on reads.
    function automatic logic [15:0] sram_f(input logic [17:0] a);
        if (a == 18'd76802) return 16'h8ABC;
        return a[15:0] ^ {a[17:16], 14'h1A5C} ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------------------
    // SRAM device model: data for the address presented at edge E appears RL edges later.
    // ------------------------------------------------------------------------------------
    logic [17:0] hist [RL+1];
    initial begin
        for (int i = 0; i <= RL; i++) hist[i] = '0;
        forever begin
            @(posedge Clock_50);
            #1;
            for (int i = RL; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = SRAM_address;
            SRAM_read_data = sram_f(hist[RL]);
        end
    end

    // ------------------------------------------------------------------------------------
    // Transaction-level reference model
    // ------------------------------------------------------------------------------------
    typedef struct {
        int          owner;
        logic [17:0] addr;
        int          due;
    } rd_t;

    rd_t         rq[$];
    int          cyc = 0;
    int          m_owner;      // -1 when nobody holds the grant
    int          m_ptr;        // next requester searched first
    int          m_pend;
    bit          m_bubble;
    bit          m_last_wr;
    logic [17:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_we_n;

    task automatic model_reset();
        rq.delete();
        m_owner   = -1;
        m_ptr     = 0;
        m_pend    = 0;
        m_bubble  = 0;
        m_last_wr = 0;
        m_addr    = '0;
        m_wdata   = '0;
        m_we_n    = 1'b1;
    endtask

    task automatic model_step();
        int w;
        rd_t r;
        cyc++;
        if (m_owner >= 0 && req_i[m_owner]) begin
            m_addr    = address_i[18*m_owner +: 18];
            m_wdata   = wdata_i[16*m_owner +: 16];
            m_we_n    = we_n_i[m_owner];
            m_last_wr = !we_n_i[m_owner];
            if (we_n_i[m_owner]) begin
                r.owner = m_owner;
                r.addr  = m_addr;
                r.due   = cyc + RL;
                rq.push_back(r);
            end
        end else begin
            m_we_n = 1'b1;
        end
        if (m_bubble) begin
            m_owner  = m_pend;
            m_bubble = 0;
        end else if (m_owner < 0 || !lock_i[m_owner]) begin
            w = -1;
            for (int i = 0; i < N; i++) begin
                if (w < 0 && req_i[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            end
            if (w < 0) begin
                m_owner = -1;
            end else begin
                m_ptr = (w + 1) % N;
`ifdef SRAM_ARB_WR_RD_BUBBLE_EN
                if (m_owner >= 0 && w != m_owner && m_last_wr) begin
                    m_bubble = 1;
                    m_pend   = w;
                    m_owner  = -1;
                end else begin
                    m_owner = w;
                end
`else
                m_owner = w;
`endif
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clock_50 or negedge Resetn);
            if (!Resetn) model_reset();
            else model_step();
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_rv;
        logic [15:0]  exp_rd;
        forever begin
            @(negedge Clock_50);
            exp_grant = '0;
            if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
            exp_rv = '0;
            exp_rd = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                exp_rv[rq[0].owner] = 1'b1;
                exp_rd = sram_f(rq[0].addr);
                void'(rq.pop_front());
            end
            chk("model grant_o", 32'(grant_o), 32'(exp_grant));
            chk("model SRAM_we_n", 32'(SRAM_we_n), 32'(m_we_n));
            chk("model SRAM_address", 32'(SRAM_address), 32'(m_addr));
            chk("model SRAM_write_data", 32'(SRAM_write_data), 32'(m_wdata));
            chk("model rvalid_o", 32'(rvalid_o), 32'(exp_rv));
            if (exp_rv != '0) chk("model rdata_o", 32'(rdata_o), 32'(exp_rd));
        end
    end

    // ------------------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------------------
    task automatic step();
        @(posedge Clock_50);
        #2;
    endtask

    task automatic idle_inputs();
        req_i     = '0;
        lock_i    = '0;
        we_n_i    = '1;
        address_i = '0;
        wdata_i   = '0;
    endtask

    task automatic set_addr(input int k, input int a);
        address_i[18*k +: 18] = 18'(a);
    endtask

    task automatic do_reset();
        idle_inputs();
        Resetn = 1'b0;
        step();
        step();
        Resetn = 1'b1;
    endtask

    initial begin
        idle_inputs();

        // 1: single read
        do_reset();
        chk("reset grant_o", 32'(grant_o), 32'h0);
        chk("reset SRAM_we_n", 32'(SRAM_we_n), 32'h1);
        req_i = 3'b001;
        set_addr(0, 76802);
        step();
        chk("t1 grant", 32'(grant_o), 32'h1);
        step();
        chk("t1 address", 32'(SRAM_address), 32'd76802);
        chk("t1 we_n", 32'(SRAM_we_n), 32'h1);
        req_i = '0;
        step();
        chk("t1 rvalid early", 32'(rvalid_o), 32'h0);
        step();
        chk("t1 rvalid", 32'(rvalid_o), 32'h1);
        chk("t1 rdata", 32'(rdata_o), 32'h8ABC);
        step();
        chk("t1 rvalid single", 32'(rvalid_o), 32'h0);

        // 2: round-robin, all reads
        do_reset();
        req_i = 3'b111;
        set_addr(0, 100);
        set_addr(1, 200);
        set_addr(2, 300);
        begin
            logic [2:0] gseq [4];
            gseq[0] = 3'b001; gseq[1] = 3'b010; gseq[2] = 3'b100; gseq[3] = 3'b001;
            for (int i = 0; i < 4; i++) begin
                step();
                chk("t2 grant seq", 32'(grant_o), 32'(gseq[i]));
            end
            chk("t2 rvalid0", 32'(rvalid_o), 32'h1);
            chk("t2 rdata0", 32'(rdata_o), 32'(sram_f(18'd100)));
            for (int i = 1; i < 4; i++) begin
                step();
                chk("t2 rvalid seq", 32'(rvalid_o), 32'(gseq[i]));
            end
        end
        idle_inputs();

        // 3: burst lock, requester 1 writes 38400..38407
        do_reset();
        req_i  = 3'b111;
        lock_i = 3'b010;
        we_n_i = 3'b101;
        set_addr(1, 38400);
        step();
        chk("t3 first grant", 32'(grant_o), 32'h1);
        step();
        chk("t3 lock grant", 32'(grant_o), 32'h2);
        for (int i = 0; i < 8; i++) begin
            set_addr(1, 38400 + i);
            wdata_i[16 +: 16] = 16'(16'hA000 + i);
            lock_i = (i == 7) ? 3'b000 : 3'b010;
            step();
            chk("t3 we_n", 32'(SRAM_we_n), 32'h0);
            chk("t3 address", 32'(SRAM_address), 32'(38400 + i));
            chk("t3 wdata", 32'(SRAM_write_data), 32'(16'hA000 + i));
            chk("t3 grant", 32'(grant_o), (i == 7) ? 32'h4 : 32'h2);
        end
        idle_inputs();

        // 4: locked idle owner blocks requester 2
        do_reset();
        req_i  = 3'b001;
        lock_i = 3'b001;
        set_addr(2, 123);
        step();
        chk("t4 grant", 32'(grant_o), 32'h1);
        req_i = 3'b100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4 grant held", 32'(grant_o), 32'h1);
            chk("t4 no access", 32'(SRAM_we_n), 32'h1);
            chk("t4 address held", 32'(SRAM_address), 32'h0);
        end
        lock_i = '0;
        step();
        chk("t4 grant moves", 32'(grant_o), 32'h4);
        step();
        chk("t4 req2 issue", 32'(SRAM_address), 32'd123);
        idle_inputs();

        // 5: reset mid-read
        do_reset();
        req_i = 3'b001;
        set_addr(0, 500);
        step();
        step();
        chk("t5 issue", 32'(SRAM_address), 32'd500);
        req_i = '0;
        step();
        Resetn = 1'b0;
        #1;
        chk("t5 rst grant", 32'(grant_o), 32'h0);
        chk("t5 rst address", 32'(SRAM_address), 32'h0);
        chk("t5 rst we_n", 32'(SRAM_we_n), 32'h1);
        chk("t5 rst wdata", 32'(SRAM_write_data), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5 rst rvalid", 32'(rvalid_o), 32'h0);
        end
        Resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5 no rvalid", 32'(rvalid_o), 32'h0);
        end

        // 6: write by 0 then read by 1
        do_reset();
        req_i  = 3'b011;
        we_n_i = 3'b110;
        set_addr(0, 5);
        set_addr(1, 777);
        step();
        chk("t6 grant0", 32'(grant_o), 32'h1);
        step();
        chk("t6 write we_n", 32'(SRAM_we_n), 32'h0);
        chk("t6 write addr", 32'(SRAM_address), 32'd5);
        req_i = 3'b010;
`ifdef SRAM_ARB_WR_RD_BUBBLE_EN
        chk("t6 bubble grant", 32'(grant_o), 32'h0);
        step();
        chk("t6 bubble we_n", 32'(SRAM_we_n), 32'h1);
        chk("t6 bubble addr", 32'(SRAM_address), 32'd5);
        chk("t6 grant1", 32'(grant_o), 32'h2);
        step();
        chk("t6 read addr", 32'(SRAM_address), 32'd777);
        chk("t6 read we_n", 32'(SRAM_we_n), 32'h1);
`else
        chk("t6 grant1", 32'(grant_o), 32'h2);
        step();
        chk("t6 read addr", 32'(SRAM_address), 32'd777);
        chk("t6 read we_n", 32'(SRAM_we_n), 32'h1);
`endif
        idle_inputs();

        // Randomized traffic checked by the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            req_i  = N'($urandom);
            lock_i = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            we_n_i = N'($urandom);
            for (int k = 0; k < N; k++) begin
                address_i[18*k +: 18] = 18'($urandom);
                wdata_i[16*k +: 16]   = 16'($urandom);
            end
            Resetn = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            step();
        end
        Resetn = 1'b1;
        idle_inputs();
        for (int i = 0; i < 10; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
